// File: rtl/demux16_pkg.sv
// rtl/demux16_pkg.sv - shared types and constants for the mux16 deserializer
package demux16_pkg;

    localparam int WORD_W      = 16;
    localparam int IDX_W       = 4;
    localparam int TIMEOUT_DEF = 32;

    localparam logic [IDX_W-1:0] FIRST_IDX = '0;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_W - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Shadow contents at frame start: bit 0 captured, every other bit cleared.
    function automatic logic [WORD_W-1:0] frame_start(input logic d);
        return {{(WORD_W-1){1'b0}}, d};
    endfunction

endpackage

// File: rtl/demux16_tmo.sv
// rtl/demux16_tmo.sv - idle-cycle watchdog for a partially collected frame
module demux16_tmo #(
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic busy,
    input  logic valid,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Fires on the TIMEOUT-th consecutive idle cycle of a frame.
    assign expire = busy && !valid && (cnt == CW'(TIMEOUT - 1));

    // Count consecutive idle cycles while busy; any bit or leaving COLLECT restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!busy || valid || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/demux16_deser.sv
// rtl/demux16_deser.sv - reassembles a 16-bit word from indexed serial bits (option: DEMUX16_TIMEOUT_EN)
module demux16_deser
    import demux16_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              D,
    input  logic [IDX_W-1:0]  C,
    input  logic              VALID,
    output logic [WORD_W-1:0] Q,
    output logic              DONE,
    output logic              BUSY,
    output logic              ERR
);

    state_t             state;
    logic [IDX_W-1:0]   exp_idx;
    logic [WORD_W-1:0]  shadow;
    logic               tmo_expire;

`ifdef DEMUX16_TIMEOUT_EN
    demux16_tmo #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk    (CLK),
        .rst_n  (RST_N),
        .busy   (BUSY),
        .valid  (VALID),
        .expire (tmo_expire)
    );
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign tmo_expire     = 1'b0;
`endif

    assign BUSY = (state == COLLECT);

    // Frame FSM: accept in-order bits, publish on index 15, abort on any skip.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            exp_idx <= '0;
            shadow  <= '0;
            Q       <= '0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            case (state)
                IDLE: begin
                    if (VALID) begin
                        if (C == FIRST_IDX) begin
                            shadow  <= frame_start(D);
                            exp_idx <= IDX_W'(1);
                            state   <= COLLECT;
                        end else begin
                            ERR <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (VALID) begin
                        if (C == exp_idx) begin
                            shadow[C] <= D;
                            if (C == LAST_IDX) begin
                                // Q takes the shadow plus this final bit on the same edge.
                                Q       <= {D, shadow[WORD_W-2:0]};
                                DONE    <= 1'b1;
                                exp_idx <= '0;
                                state   <= IDLE;
                            end else begin
                                exp_idx <= exp_idx + 1'b1;
                            end
                        end else begin
                            ERR <= 1'b1;
                            if (C == FIRST_IDX) begin
                                // An out-of-order index 0 is the start of a fresh frame.
                                shadow  <= frame_start(D);
                                exp_idx <= IDX_W'(1);
                            end else begin
                                exp_idx <= '0;
                                state   <= IDLE;
                            end
                        end
                    end else if (tmo_expire) begin
                        ERR     <= 1'b1;
                        exp_idx <= '0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    exp_idx <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
